// File: rtl/multicast_bus.sv
// multicast_bus: tag-addressed multicast from one upstream port to NUM_TARGETS
// downstream targets. Incoming {tag, word} pairs are queued in a small FIFO.
// The head word is delivered to every target whose scan-programmed tag
// matches, and each target is served independently as it becomes ready.
// The all-ones tag can optionally act as a broadcast.
//
// "program" is a reserved word in SystemVerilog, so the scan-shift enable
// port is named program_en.
module multicast_bus #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int BITWIDTH      = 16,
  parameter int NUM_TARGETS   = 4,
  parameter int DEPTH         = 4,
  parameter int BROADCAST_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     program_en,
  input  logic [ADDRESS_WIDTH-1:0] scan_tag_in,
  output logic [ADDRESS_WIDTH-1:0] scan_tag_out,
  input  logic                     bus_enable,
  output logic                     bus_ready,
  input  logic [ADDRESS_WIDTH-1:0] tag,
  input  logic [BITWIDTH-1:0]      bus_data,
  output logic [NUM_TARGETS-1:0]   target_enable,
  input  logic [NUM_TARGETS-1:0]   target_ready,
  output logic [BITWIDTH-1:0]      target_data,
  output logic                     busy,
  output logic [15:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]         FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] BCAST_TAG = {ADDRESS_WIDTH{1'b1}};

  // Scan-programmed target tags and registered scan output.
  logic [ADDRESS_WIDTH-1:0] tag_reg_q [NUM_TARGETS];
  logic [ADDRESS_WIDTH-1:0] scan_tag_out_q;

  // Input FIFO storage and bookkeeping.
  logic [ADDRESS_WIDTH-1:0] fifo_tag_q  [DEPTH];
  logic [BITWIDTH-1:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  // Head stage: the word currently being delivered.
  logic                   head_valid_q, head_valid_d;
  logic [BITWIDTH-1:0]    head_data_q,  head_data_d;
  logic [NUM_TARGETS-1:0] pending_q,    pending_d;
  logic [15:0]            drop_count_q, drop_count_d;

  // Combinational helpers.
  logic                     fifo_empty_s;
  logic                     fifo_full_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     head_free_s;
  logic [ADDRESS_WIDTH-1:0] fifo_head_tag_s;
  logic [NUM_TARGETS-1:0]   tag_match_s;
  logic                     bcast_s;
  logic [NUM_TARGETS-1:0]   match_s;
  logic [NUM_TARGETS-1:0]   target_enable_s;
  logic [NUM_TARGETS-1:0]   remaining_s;

  assign fifo_empty_s    = (count_q == {CNT_W{1'b0}});
  assign fifo_full_s     = (count_q == FULL_CNT);
  assign bus_ready       = ~fifo_full_s & ~program_en;
  assign push_s          = bus_enable & bus_ready;
  assign fifo_head_tag_s = fifo_tag_q[rd_ptr_q];

  // Delivery strobes. Programming freezes delivery without losing the head.
  assign target_enable_s = {NUM_TARGETS{head_valid_q & ~program_en}} & pending_q & target_ready;
  assign remaining_s     = pending_q & ~target_enable_s;

  // The head slot can take a new word when it is empty, or when this cycle
  // completes its last outstanding delivery (back-to-back streaming).
  assign head_free_s = ~head_valid_q | (remaining_s == {NUM_TARGETS{1'b0}});
  assign pop_s       = head_free_s & ~program_en & ~fifo_empty_s;

  assign target_enable = target_enable_s;
  assign target_data   = (|target_enable_s) ? head_data_q : {BITWIDTH{1'b0}};
  assign busy          = head_valid_q | ~fifo_empty_s;
  assign drop_count    = drop_count_q;
  assign scan_tag_out  = scan_tag_out_q;

  // Match mask of the FIFO head entry against the programmed target tags.
  always_comb begin
    tag_match_s = {NUM_TARGETS{1'b0}};
    for (int i = 0; i < NUM_TARGETS; i++) begin
      tag_match_s[i] = (tag_reg_q[i] == fifo_head_tag_s);
    end
    bcast_s = (BROADCAST_EN != 0) && (fifo_head_tag_s == BCAST_TAG);
    match_s = bcast_s ? {NUM_TARGETS{1'b1}} : tag_match_s;
  end

  // Next state of the head stage: load or drop on pop, retire when done.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    pending_d    = remaining_s;
    drop_count_d = drop_count_q;
    if (pop_s) begin
      if (match_s != {NUM_TARGETS{1'b0}}) begin
        head_valid_d = 1'b1;
        head_data_d  = fifo_data_q[rd_ptr_q];
        pending_d    = match_s;
      end else begin
        head_valid_d = 1'b0;
        pending_d    = {NUM_TARGETS{1'b0}};
        if (drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end else begin
          drop_count_d = drop_count_q;
        end
      end
    end else if (head_valid_q && (remaining_s == {NUM_TARGETS{1'b0}})) begin
      head_valid_d = 1'b0;
      pending_d    = {NUM_TARGETS{1'b0}};
    end else begin
      head_valid_d = head_valid_q;
    end
  end

  // Scan chain: shift tags toward the last target while programming.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        tag_reg_q[i] <= {ADDRESS_WIDTH{1'b0}};
      end
      scan_tag_out_q <= {ADDRESS_WIDTH{1'b0}};
    end else if (program_en) begin
      tag_reg_q[0] <= scan_tag_in;
      for (int i = 1; i < NUM_TARGETS; i++) begin
        tag_reg_q[i] <= tag_reg_q[i-1];
      end
      scan_tag_out_q <= tag_reg_q[NUM_TARGETS-1];
    end
  end

  // Input FIFO: write on push, advance read pointer on pop, track occupancy.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_tag_q[i]  <= {ADDRESS_WIDTH{1'b0}};
        fifo_data_q[i] <= {BITWIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_tag_q[wr_ptr_q]  <= tag;
        fifo_data_q[wr_ptr_q] <= bus_data;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head stage and drop counter registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      head_valid_q <= 1'b0;
      head_data_q  <= {BITWIDTH{1'b0}};
      pending_q    <= {NUM_TARGETS{1'b0}};
      drop_count_q <= 16'd0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      pending_q    <= pending_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_multicast_bus.sv
// Self-checking bench for multicast_bus: a reference model computes, for every
// accepted word, which targets must receive it (per-target ordered queues)
// or whether it is dropped. A negedge monitor pops and compares each delivery.
module tb_multicast_bus;

  localparam int AW = 4;
  localparam int BW = 16;
  localparam int NT = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          program_en = 1'b0;
  logic [AW-1:0] scan_tag_in = 4'd0;
  logic [AW-1:0] scan_tag_out;
  logic          bus_enable = 1'b0;
  logic          bus_ready;
  logic [AW-1:0] tag = 4'd0;
  logic [BW-1:0] bus_data = 16'd0;
  logic [NT-1:0] target_enable;
  logic [NT-1:0] target_ready = 4'd0;
  logic [BW-1:0] target_data;
  logic          busy;
  logic [15:0]   drop_count;

  multicast_bus #(
    .ADDRESS_WIDTH(AW), .BITWIDTH(BW), .NUM_TARGETS(NT), .DEPTH(DP), .BROADCAST_EN(1)
  ) dut (
    .clk(clk), .rstb(rstb), .program_en(program_en),
    .scan_tag_in(scan_tag_in), .scan_tag_out(scan_tag_out),
    .bus_enable(bus_enable), .bus_ready(bus_ready), .tag(tag), .bus_data(bus_data),
    .target_enable(target_enable), .target_ready(target_ready),
    .target_data(target_data), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [BW-1:0] exp_q [NT][$];
  logic [AW-1:0] mt [NT];
  int            exp_drops = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set of targets a tag addresses under the current model tags.
  function automatic logic [NT-1:0] model_mask(input logic [AW-1:0] t);
    logic [NT-1:0] m;
    m = 4'd0;
    if (t == 4'hF) begin
      m = 4'hF;
    end else begin
      for (int i = 0; i < NT; i++) if (mt[i] == t) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_accept(input logic [AW-1:0] t, input logic [BW-1:0] d);
    logic [NT-1:0] m;
    m = model_mask(t);
    if (m == 4'd0) exp_drops++;
    else for (int i = 0; i < NT; i++) if (m[i]) exp_q[i].push_back(d);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      exp_q[i].delete();
      mt[i] = 4'd0;
    end
    exp_drops = 0;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [AW-1:0] t, input logic [BW-1:0] d, output bit acc);
    bus_enable = 1'b1;
    tag = t;
    bus_data = d;
    @(negedge clk);
    acc = bus_ready;
    if (acc) model_accept(t, d);
    tick();
    bus_enable = 1'b0;
  endtask

  task automatic program_tags(input logic [AW-1:0] t0, input logic [AW-1:0] t1,
                              input logic [AW-1:0] t2, input logic [AW-1:0] t3);
    logic [AW-1:0] old0;
    logic [AW-1:0] seq [4];
    old0 = mt[0];
    seq = '{t3, t2, t1, t0};
    program_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      scan_tag_in = seq[k];
      tick();
    end
    program_en = 1'b0;
    mt = '{t0, t1, t2, t3};
    check("scan_out_after_load", 32'(scan_tag_out), 32'(old0));
  endtask

  // Monitor: every delivery strobe must match the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [BW-1:0] e;
    if (rstb && mon_en) begin
      for (int i = 0; i < NT; i++) begin
        if (target_enable[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_enable t%0d: got data %0h expected no delivery at %0t",
                     i, target_data, $time);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("deliver_t%0d", i), 32'(target_data), 32'(e));
          end
        end
      end
      if (target_enable == 4'd0) check("idle_data_zero", 32'(target_data), 32'd0);
    end
  end

  initial begin : main
    bit acc;
    int acc_cnt;
    int run;
    int r;
    bit drained;
    logic [AW-1:0] tpick [3];

    for (int i = 0; i < NT; i++) mt[i] = 4'd0;
    tpick = '{4'd1, 4'd2, 4'd3};

    // Reset state.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(target_enable), 32'd0);
    check("rst_data", 32'(target_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ready", 32'(bus_ready), 32'd1);
    check("rst_scan_out", 32'(scan_tag_out), 32'd0);
    tick();
    rstb = 1'b1;
    mon_en = 1'b1;

    // Scan chain: shift 1,2,3,4 then one more.
    program_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      scan_tag_in = 4'(k);
      tick();
    end
    check("scan_ready_blocked", 32'(bus_ready), 32'd0);
    check("scan_out_4", 32'(scan_tag_out), 32'd0);
    scan_tag_in = 4'd0;
    tick();
    check("scan_out_5", 32'(scan_tag_out), 32'd1);
    program_en = 1'b0;
    mt = '{4'd0, 4'd4, 4'd3, 4'd2};
    program_tags(4'd1, 4'd2, 4'd1, 4'd3);

    // Multicast with latency and single-cycle strobe.
    target_ready = 4'hF;
    push_word(4'd1, 16'hABCD, acc);
    check("mc_accept", 32'(acc), 32'd1);
    @(negedge clk);
    check("mc_not_early", 32'(target_enable), 32'd0);
    tick();
    @(negedge clk);
    check("mc_enable", 32'(target_enable), 32'(4'b0101));
    check("mc_data", 32'(target_data), 32'hABCD);
    tick();
    @(negedge clk);
    check("mc_single", 32'(target_enable), 32'd0);
    tick();

    // Partial multicast with a slow target.
    target_ready = 4'b1011;
    push_word(4'd1, 16'h1111, acc);
    push_word(4'd2, 16'h2222, acc);
    @(negedge clk);
    check("part_first", 32'(target_enable), 32'(4'b0001));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("part_wait_en", 32'(target_enable), 32'd0);
      check("part_busy", 32'(busy), 32'd1);
    end
    tick();
    target_ready = 4'hF;
    @(negedge clk);
    check("part_slow_served", 32'(target_enable), 32'(4'b0100));
    check("part_busy2", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("part_next_word", 32'(target_enable), 32'(4'b0010));
    tick();
    @(negedge clk);
    check("part_idle", 32'(busy), 32'd0);
    tick();

    // Broadcast and drop.
    push_word(4'hF, 16'h3333, acc);
    tick();
    @(negedge clk);
    check("bcast_enable", 32'(target_enable), 32'hF);
    tick();
    push_word(4'd7, 16'h4444, acc);
    tick();
    tick();
    tick();
    check("drop_count_1", 32'(drop_count), 32'd1);

    // Loaded head keeps its mask while tags are reprogrammed.
    target_ready = 4'd0;
    push_word(4'd1, 16'h5555, acc);
    tick();
    tick();
    program_tags(4'd9, 4'd9, 4'd9, 4'd9);
    target_ready = 4'hF;
    @(negedge clk);
    check("frozen_mask", 32'(target_enable), 32'(4'b0101));
    tick();
    tick();
    program_tags(4'd1, 4'd2, 4'd1, 4'd3);

    // Back-pressure: FIFO plus head absorb DEPTH+1 words.
    target_ready = 4'd0;
    acc_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      push_word(4'hF, 16'(16'h6000 + j), acc);
      acc_cnt += int'(acc);
    end
    check("full_accepted", 32'(acc_cnt), 32'(DP + 1));
    check("full_not_ready", 32'(bus_ready), 32'd0);
    target_ready = 4'hF;
    run = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (target_enable == 4'hF) run++;
      tick();
    end
    check("full_stream_rate", 32'(run), 32'd5);
    @(negedge clk);
    check("full_drained", 32'(busy), 32'd0);
    tick();

    // Reset in the middle of traffic.
    target_ready = 4'd0;
    for (int j = 0; j < 3; j++) push_word(4'hF, 16'(16'h7000 + j), acc);
    tick();
    rstb = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_enable", 32'(target_enable), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_ready", 32'(bus_ready), 32'd1);
    model_reset();
    tick();
    rstb = 1'b1;
    target_ready = 4'hF;
    for (int j = 0; j < 5; j++) tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    program_tags(4'd1, 4'd2, 4'd1, 4'd3);

    // Randomized traffic with random per-target readiness.
    for (int c = 0; c < 400; c++) begin
      target_ready = 4'($urandom_range(0, 15));
      bus_enable = ($urandom_range(0, 99) < 60);
      r = int'($urandom_range(0, 9));
      if (r < 7) tag = tpick[r % 3];
      else if (r == 7) tag = 4'hF;
      else tag = 4'($urandom_range(4, 14));
      bus_data = 16'($urandom);
      @(negedge clk);
      if (bus_enable && bus_ready) model_accept(tag, bus_data);
      tick();
    end
    bus_enable = 1'b0;
    target_ready = 4'hF;
    drained = 1'b0;
    for (int c = 0; c < 50 && !drained; c++) begin
      tick();
      if (!busy) drained = 1'b1;
    end
    check("drain_timeout", 32'(drained), 32'd1);
    tick();
    for (int i = 0; i < NT; i++)
      check($sformatf("leftover_t%0d", i), 32'(exp_q[i].size()), 32'd0);
    check("drop_total", 32'(drop_count), 32'(exp_drops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
